// File: rtl/sextium_iochan.sv
// rtl/sextium_iochan.sv - multi-channel I/O and frame port controller
//
// Purpose: runs one read, write or write-then-read exchange on one of
// 2^CH_BITS peripheral channels per runio request. Each strobe phase waits
// for the selected channel's ack and gives up after TIMEOUT cycles. The
// result (rdata, status) is handed to the core with a one-cycle acc_write.
//
// Ports:
//   clock, reset        system clock, asynchronous active-low reset
//   runio, cmd, chan,   start request and its operands (sampled in IDLE)
//   wdata
//   iobusy, acc_write   handshake back to the core controller
//   rdata, status       registered result, held until the next DONE
//   ch_read, ch_write   one-hot per-channel strobes
//   ch_data_out         shared write data
//   ch_ack, ch_data_in  per-channel acknowledge and read data
module sextium_iochan #(
  parameter int WIDTH   = 16,
  parameter int CH_BITS = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            runio,
  input  logic [1:0]                      cmd,
  input  logic [CH_BITS-1:0]              chan,
  input  logic [WIDTH-1:0]                wdata,
  output logic                            iobusy,
  output logic                            acc_write,
  output logic [WIDTH-1:0]                rdata,
  output logic [1:0]                      status,
  output logic [(1<<CH_BITS)-1:0]         ch_read,
  output logic [(1<<CH_BITS)-1:0]         ch_write,
  output logic [WIDTH-1:0]                ch_data_out,
  input  logic [(1<<CH_BITS)-1:0]         ch_ack,
  input  logic [(1<<CH_BITS)*WIDTH-1:0]   ch_data_in
);

  localparam int CHANNELS = 1 << CH_BITS;
  // Last counter value of a phase; unused when the timeout is disabled.
  localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  localparam logic [1:0] CMD_READ  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_XCHG  = 2'd2;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_BADCMD  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_ERR,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           cmd_q, cmd_d;
  logic [CH_BITS-1:0]   chan_q, chan_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic [1:0]           status_q, status_d;

  logic [WIDTH-1:0]     ch_word [CHANNELS];
  logic [CHANNELS-1:0]  sel_oh;
  logic                 ack_sel;
  logic                 to_hit;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_slice
    assign ch_word[k] = ch_data_in[k*WIDTH +: WIDTH];
  end

  assign sel_oh  = CHANNELS'(1) << chan_q;
  assign ack_sel = ch_ack[chan_q];
  // The phase gives up on the cycle the counter reaches TIMEOUT-1 without ack,
  // so the strobe has been high for exactly TIMEOUT cycles.
  assign to_hit  = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      chan_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      chan_q   <= chan_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    chan_d   = chan_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    unique case (state_q)
      S_IDLE: begin
        if (runio) begin
          cmd_d   = cmd;
          chan_d  = chan;
          wdata_d = wdata;
          cnt_d   = '0;
          unique case (cmd)
            CMD_READ:  state_d = S_RD;
            CMD_WRITE: state_d = S_WR;
            CMD_XCHG:  state_d = S_WR;
            default:   state_d = S_ERR;
          endcase
        end
      end
      S_WR: begin
        if (ack_sel) begin
          cnt_d = '0;
          if (cmd_q == CMD_XCHG) begin
            state_d = S_RD;
          end else begin
            rdata_d  = '0;
            status_d = ST_OK;
            state_d  = S_DONE;
          end
        end else if (to_hit) begin
          rdata_d  = '0;
          status_d = ST_TIMEOUT;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RD: begin
        if (ack_sel) begin
          rdata_d  = ch_word[chan_q];
          status_d = ST_OK;
          state_d  = S_DONE;
        end else if (to_hit) begin
          rdata_d  = '0;
          status_d = ST_TIMEOUT;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ERR: begin
        rdata_d  = '0;
        status_d = ST_BADCMD;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Everything below decodes registered state only, so the async reset
  // drops the strobes immediately and no input reaches an output directly.
  assign iobusy      = (state_q != S_IDLE);
  assign acc_write   = (state_q == S_DONE);
  assign ch_write    = (state_q == S_WR) ? sel_oh : '0;
  assign ch_read     = (state_q == S_RD) ? sel_oh : '0;
  assign ch_data_out = wdata_q;
  assign rdata       = rdata_q;
  assign status      = status_q;

endmodule

// File: tb/tb_sextium_iochan.sv
// tb/tb_sextium_iochan.sv - self-checking bench for sextium_iochan
module tb_sextium_iochan;

  localparam int WIDTH   = 16;
  localparam int CH_BITS = 2;
  localparam int CHN     = 4;
  localparam int TIMEOUT = 8;
  localparam int NOACK   = 1000;

  logic                   clock;
  logic                   reset;
  logic                   runio;
  logic [1:0]             cmd;
  logic [CH_BITS-1:0]     chan;
  logic [WIDTH-1:0]       wdata;
  logic                   iobusy;
  logic                   acc_write;
  logic [WIDTH-1:0]       rdata;
  logic [1:0]             status;
  logic [CHN-1:0]         ch_read;
  logic [CHN-1:0]         ch_write;
  logic [WIDTH-1:0]       ch_data_out;
  logic [CHN-1:0]         ch_ack;
  logic [CHN*WIDTH-1:0]   ch_data_in;

  int nvec = 0;
  int nmis = 0;

  sextium_iochan #(.WIDTH(WIDTH), .CH_BITS(CH_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .runio(runio), .cmd(cmd), .chan(chan),
    .wdata(wdata), .iobusy(iobusy), .acc_write(acc_write), .rdata(rdata),
    .status(status), .ch_read(ch_read), .ch_write(ch_write),
    .ch_data_out(ch_data_out), .ch_ack(ch_ack), .ch_data_in(ch_data_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe cycles spent in one phase whose ack comes d cycles into it.
  function automatic int phase_len(input int d);
    return (d < TIMEOUT) ? d + 1 : TIMEOUT;
  endfunction

  // Reference outcome of one transfer from the operation rules.
  task automatic model(input int c, input int dw, input int dr, input logic [15:0] rd,
                       output int lat, output int wr_s, output int rd_s,
                       output logic [15:0] er, output logic [1:0] es);
    wr_s = 0; rd_s = 0; er = 16'h0; es = 2'd0;
    case (c)
      0: begin
        rd_s = phase_len(dr);
        if (dr >= TIMEOUT) es = 2'd1; else er = rd;
      end
      1: begin
        wr_s = phase_len(dw);
        if (dw >= TIMEOUT) es = 2'd1;
      end
      2: begin
        wr_s = phase_len(dw);
        if (dw >= TIMEOUT) es = 2'd1;
        else begin
          rd_s = phase_len(dr);
          if (dr >= TIMEOUT) es = 2'd1; else er = rd;
        end
      end
      default: es = 2'd2;
    endcase
    lat = 1 + wr_s + rd_s + ((c == 3) ? 1 : 0);
  endtask

  task automatic xfer(input int c, input int ch, input logic [15:0] wd,
                      input int dw, input int dr, input logic [15:0] rd);
    int lat_e, wr_e, rd_e, lat, wn, rn;
    logic [15:0] er;
    logic [1:0] es;
    logic [CHN-1:0] oh, ack;
    bit done;
    model(c, dw, dr, rd, lat_e, wr_e, rd_e, er, es);
    oh = CHN'(1) << ch;
    for (int k = 0; k < CHN; k++) ch_data_in[k*WIDTH +: WIDTH] = 16'($urandom);
    ch_data_in[ch*WIDTH +: WIDTH] = rd;
    runio = 1'b1; cmd = 2'(c); chan = CH_BITS'(ch); wdata = wd;
    ch_ack = 4'($urandom) & ~oh;
    wn = 0; rn = 0; lat = 0; done = 0;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(posedge clock); #1;
      // Scramble the request inputs to show they were latched at start
      // and that runio during busy is ignored.
      runio = 1'($urandom);
      cmd = 2'($urandom); chan = CH_BITS'($urandom); wdata = 16'($urandom);
      ack = 4'($urandom) & ~oh;
      chk("busy", iobusy, 1);
      if (ch_write != 0) begin
        chk("wr_onehot", ch_write, oh);
        chk("wr_rd_overlap", ch_read, 0);
        chk("wr_data_out", ch_data_out, wd);
        if (wn == dw) ack = ack | oh;
        wn++;
      end
      if (ch_read != 0) begin
        chk("rd_onehot", ch_read, oh);
        if (rn == dr) ack = ack | oh;
        rn++;
      end
      if (acc_write) begin
        done = 1; lat = cyc; runio = 1'b0;
        chk("done_strobes", {ch_read, ch_write}, 0);
      end
      ch_ack = ack;
    end
    chk("done_seen", done, 1);
    chk("latency", lat, lat_e);
    chk("wr_cycles", wn, wr_e);
    chk("rd_cycles", rn, rd_e);
    chk("rdata", rdata, er);
    chk("status", status, es);
    @(posedge clock); #1;
    ch_ack = 4'($urandom);
    chk("idle_after", iobusy, 0);
    chk("no_second_acc", acc_write, 0);
    chk("data_out_hold", ch_data_out, wd);
    @(posedge clock); #1;
    chk("result_hold", {rdata, status}, {er, es});
    ch_ack = '0;
  endtask

  initial begin
    reset = 1'b0; runio = 1'b0; cmd = '0; chan = '0; wdata = '0;
    ch_ack = '0; ch_data_in = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outs", {iobusy, acc_write, rdata, status, ch_read, ch_write, ch_data_out}, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Reset in the middle of a read on channel 2.
    runio = 1'b1; cmd = 2'd0; chan = 2'd2; wdata = 16'hCAFE;
    @(posedge clock); #1;
    runio = 1'b0;
    @(posedge clock); #1;
    chk("pre_reset_rd", ch_read, 4'b0100);
    #2 reset = 1'b0;
    #1;
    chk("async_reset", {iobusy, acc_write, rdata, status, ch_read, ch_write, ch_data_out}, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("reset_no_acc", {acc_write, iobusy}, 0);
    end
    reset = 1'b1;
    @(posedge clock); #1;

    xfer(0, 1, 16'h0000, 0, 0, 16'hBEEF);
    xfer(1, 3, 16'h1234, 5, 0, 16'h7777);
    xfer(2, 0, 16'h00A5, 2, 0, 16'h5A00);
    xfer(0, 2, 16'h0101, 0, NOACK, 16'h9999);
    xfer(3, 1, 16'h4242, 0, 0, 16'h3333);
    xfer(1, 2, 16'hFFFF, TIMEOUT - 1, 0, 16'h0);
    xfer(2, 3, 16'h8001, NOACK, 0, 16'hABCD);
    xfer(2, 1, 16'h0F0F, 0, NOACK, 16'hABCD);

    for (int i = 0; i < 40; i++) begin
      xfer(int'($urandom_range(0, 3)), int'($urandom_range(0, CHN - 1)), 16'($urandom),
           int'($urandom_range(0, 10)), int'($urandom_range(0, 10)), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
